// File: rtl/rom_stream_reader.sv
// Sequencer in front of a registered-output ROM: walks length words from base_addr
// and delivers them as a valid/ready stream. Optional ROM_READER_LOOP_EN adds pass looping.
module rom_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
`ifdef ROM_READER_LOOP_EN
    input  logic                  loop,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int ACW = LEN_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [ACW-1:0]        accept_cnt_q, accept_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  done_q, done_d;
`ifdef ROM_READER_LOOP_EN
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
`endif

    logic       pop;
    logic       rd_en;
    logic [1:0] level;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        issue_cnt_d  = issue_cnt_q;
        accept_cnt_d = accept_cnt_q;
        head_d       = head_q;
        tail_d       = tail_q;
        occ_d        = occ_q;
        done_d       = 1'b0;
`ifdef ROM_READER_LOOP_EN
        base_d       = base_q;
        len_d        = len_q;
`endif

        pop   = (occ_q != 2'd0) && out_ready;
        // words buffered or in flight once this cycle's pop retires
        level = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        rd_en = (state_q == S_RUN) && (issue_cnt_q != '0) && (level < 2'd2);

        rom_addr   = rd_en ? ptr_q : addr_q;
        addr_d     = rom_addr;
        inflight_d = rd_en;

        if (rd_en) begin
            ptr_d       = ptr_q + ADDR_WIDTH'(1);
            issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
        end
        if (pop) begin
            accept_cnt_d = accept_cnt_q - ACW'(1);
        end

        if (inflight_q && pop) begin
            if (occ_q == 2'd2) begin
                head_d = tail_q;
                tail_d = rom_data;
            end else begin
                head_d = rom_data;
            end
        end else if (inflight_q) begin
            if (occ_q == 2'd0) begin
                head_d = rom_data;
            end else begin
                tail_d = rom_data;
            end
            occ_d = occ_q + 2'd1;
        end else if (pop) begin
            if (occ_q == 2'd2) begin
                head_d = tail_q;
            end
            occ_d = occ_q - 2'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d      = S_RUN;
                        ptr_d        = base_addr;
                        issue_cnt_d  = length;
                        accept_cnt_d = ACW'(length);
`ifdef ROM_READER_LOOP_EN
                        base_d       = base_addr;
                        len_d        = length;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (rd_en && (issue_cnt_q == LEN_WIDTH'(1))) begin
`ifdef ROM_READER_LOOP_EN
                    if (loop) begin
                        ptr_d        = base_q;
                        issue_cnt_d  = len_q;
                        accept_cnt_d = accept_cnt_q - ACW'(pop) + ACW'(len_q);
                    end else begin
                        state_d = S_DRAIN;
                    end
`else
                    state_d = S_DRAIN;
`endif
                end
            end
            S_DRAIN: begin
                if (accept_cnt_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            addr_q       <= '0;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
            inflight_q   <= 1'b0;
            occ_q        <= 2'd0;
            head_q       <= '0;
            tail_q       <= '0;
            done_q       <= 1'b0;
`ifdef ROM_READER_LOOP_EN
            base_q       <= '0;
            len_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            addr_q       <= addr_d;
            issue_cnt_q  <= issue_cnt_d;
            accept_cnt_q <= accept_cnt_d;
            inflight_q   <= inflight_d;
            occ_q        <= occ_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            done_q       <= done_d;
`ifdef ROM_READER_LOOP_EN
            base_q       <= base_d;
            len_q        <= len_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign rom_rd_en = rd_en;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader with a behavioural registered-output ROM.
// Define ROM_READER_LOOP_EN to also exercise pass looping.
module tb_rom_stream_reader;

    logic        clk;
    logic        rst_b;
    logic        start;
    logic [1:0]  base_addr;
    logic [2:0]  length;
`ifdef ROM_READER_LOOP_EN
    logic        loop;
`endif
    logic        busy;
    logic        done;
    logic        rom_rd_en;
    logic [1:0]  rom_addr;
    logic [31:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    rom_stream_reader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(2),
        .LEN_WIDTH(3)
    ) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
`ifdef ROM_READER_LOOP_EN
        .loop     (loop),
`endif
        .busy     (busy),
        .done     (done),
        .rom_rd_en(rom_rd_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    localparam logic [31:0] D0 = 32'h00010203;
    localparam logic [31:0] D1 = 32'h04050607;
    localparam logic [31:0] D2 = 32'h08090A0B;
    localparam logic [31:0] D3 = 32'h0C0D0E0F;

    logic [31:0] rom_mem [4];
    initial begin
        rom_mem[0] = D0;
        rom_mem[1] = D1;
        rom_mem[2] = D2;
        rom_mem[3] = D3;
    end

    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom_mem[rom_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    logic [31:0] exp_q[$];
    logic [1:0]  addr_exp_q[$];
    int first_rd, first_val, last_hs, done_cyc;
    int done_cnt, rd_cnt, issued, accepted;
    bit busy_seen;

    task automatic clear_rec();
        exp_q.delete();
        addr_exp_q.delete();
        first_rd  = -1;
        first_val = -1;
        last_hs   = -1;
        done_cyc  = -1;
        done_cnt  = 0;
        rd_cnt    = 0;
        issued    = 0;
        accepted  = 0;
        busy_seen = 1'b0;
    endtask

    // monitor: compares every presented word against the scoreboard head
    always @(negedge clk) begin
        if (rst_b) begin
            if (rom_rd_en) begin
                chk("credit", ((issued - accepted
                    - ((out_valid && out_ready) ? 1 : 0)) <= 1), 1);
                if (addr_exp_q.size() == 0)
                    chk("rom_addr_extra", addr_exp_q.size(), 1);
                else
                    chk("rom_addr", rom_addr, addr_exp_q.pop_front());
                if (first_rd < 0) first_rd = cyc;
                rd_cnt++;
                issued++;
            end
            if (out_valid) begin
                if (first_val < 0) first_val = cyc;
                if (exp_q.size() == 0) begin
                    chk("out_valid_extra", exp_q.size(), 1);
                end else begin
                    chk("out_data", out_data, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        accepted++;
                        last_hs = cyc;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic do_start(input int b, input int l, output int c0);
        @(posedge clk); #1;
        base_addr = 2'(b);
        length    = 3'(l);
        start     = 1'b1;
        c0        = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", (done_cnt != 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, rom_rd_en, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int n;
        logic [15:0] pat;

        rst_b     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
`ifdef ROM_READER_LOOP_EN
        loop      = 1'b0;
`endif
        clear_rec();
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        chk_outputs_zero("reset");

        // 1: base 0, length 4, continuous ready
        clear_rec();
        addr_exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        exp_q      = '{D0, D1, D2, D3};
        do_start(0, 4, c0);
        @(negedge clk);
        chk("t1_busy", busy, 1);
        wait_done(30);
        chk("t1_first_rd", first_rd, c0 + 1);
        chk("t1_first_val", first_val, c0 + 3);
        chk("t1_last_hs", last_hs, c0 + 6);
        chk("t1_done_cyc", done_cyc, c0 + 7);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_left", exp_q.size() + addr_exp_q.size(), 0);

        // 2: wrap-around
        clear_rec();
        addr_exp_q = '{2'd3, 2'd0, 2'd1};
        exp_q      = '{D3, D0, D1};
        do_start(3, 3, c0);
        wait_done(30);
        chk("t2_done_cyc", done_cyc, c0 + 6);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_left", exp_q.size() + addr_exp_q.size(), 0);

        // 3: backpressure
        clear_rec();
        addr_exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        exp_q      = '{D0, D1, D2, D3};
        pat = 16'b1111_0100_0110_1001;
        do_start(0, 4, c0);
        n = 0;
        while (done_cnt == 0 && n < 60) begin
            out_ready = pat[n & 15];
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        wait_done(10);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_accepted", accepted, 4);
        chk("t3_left", exp_q.size() + addr_exp_q.size(), 0);

        // 4: zero length
        clear_rec();
        do_start(1, 0, c0);
        @(negedge clk);
        chk("t4_done_now", done, 1);
        chk("t4_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_rd_cnt", rd_cnt, 0);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_done_cyc", done_cyc, c0 + 1);
        chk("t4_busy_seen", busy_seen, 0);

        // 5: restart ignored while busy, then reset mid-transfer
        clear_rec();
        addr_exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        exp_q      = '{D0, D1, D2, D3};
        do_start(0, 4, c0);
        base_addr = 2'd2;
        length    = 3'd1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (accepted < 2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_two_words", accepted, 2);
        rst_b = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(negedge clk);
        chk_outputs_zero("t5_abort");
        clear_rec();
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_done", done_cnt, 0);
        chk("t5_no_valid", first_val, -1);
        clear_rec();
        addr_exp_q = '{2'd1, 2'd2};
        exp_q      = '{D1, D2};
        do_start(1, 2, c0);
        wait_done(30);
        chk("t5_done_cyc", done_cyc, c0 + 5);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_left", exp_q.size() + addr_exp_q.size(), 0);

`ifdef ROM_READER_LOOP_EN
        // 6: three back-to-back passes
        clear_rec();
        for (int p = 0; p < 3; p++) begin
            addr_exp_q.push_back(2'd2);
            addr_exp_q.push_back(2'd3);
            exp_q.push_back(D2);
            exp_q.push_back(D3);
        end
        loop = 1'b1;
        do_start(2, 2, c0);
        n = 0;
        while (rd_cnt < 4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        loop = 1'b0;
        wait_done(40);
        chk("t6_last_hs", last_hs, c0 + 8);
        chk("t6_done_cyc", done_cyc, c0 + 9);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_left", exp_q.size() + addr_exp_q.size(), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
